dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Sequencer and two-port arbiter in front of the byte-addressed data RAM (128 B, negedge write, combinational read, u/b/h/w size encoding, load/store access-fault outputs).
- Shares the RAM between requester 0 (core MEM stage) and requester 1 (debug/DMA loader) with a req/ack handshake.
- Registers each access through a fixed 3-state sequence and returns read data and fault status with ack.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin arbitration; 1 = requester 0 always wins ties.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- m0_req  input  1  requester 0 access request; held until m0_ack.
- m0_we  input  1  1 = store, 0 = load.
- m0_addr  input  32  byte address.
- m0_wdata  input  32  store data, LSB-aligned.
- m0_size  input  3  bit0 = half, bit1 = word, bit2 = unsigned; 000 = signed byte.
- m0_ack  output  1  one-cycle completion pulse.
- m0_rdata  output  32  load data; valid while m0_ack = 1.
- m0_fault  output  1  access fault; valid while m0_ack = 1.
- m1_req, m1_we, m1_addr, m1_wdata, m1_size, m1_ack, m1_rdata, m1_fault: same as m0_*, for requester 1.
- ram_addr  output  32  RAM address.
- ram_din  output  32  RAM write data.
- ram_we  output  1  RAM write enable.
- ram_re  output  1  RAM read enable.
- ram_u_b_h_w  output  3  RAM size code; m*_size passed through.
- ram_dout  input  32  RAM read data, combinational.
- ram_l_fault  input  1  RAM load access fault.
- ram_s_fault  input  1  RAM store access fault.

Behaviour:
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, pick the winner, latch its we/addr/wdata/size and an owner bit, then go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration:
  - Single requester: that requester wins.
  - Both requesting, FIXED_PRIO = 1: m0 wins.
  - Both requesting, FIXED_PRIO = 0: the requester not granted last wins.
  - last_grant updates on each grant.
- ACCESS (exactly 1 cycle):
  - Drive ram_* from the latched values; ram_we = latched we; ram_re = ~latched we.
  - RAM write lands on the negedge inside this cycle.
  - At the closing rising edge, capture ram_dout and fault (ram_l_fault | ram_s_fault), then go to RESP.
- RESP (1 cycle):
  - Owner's ack = 1; owner's rdata = captured data; owner's fault = captured fault. Non-owner outputs stay 0.
  - Go to IDLE. A req still high in IDLE is a new request; requesters deassert req in the cycle after ack.
- ram_we and ram_re are 0 in IDLE and RESP. ram_addr, ram_din and ram_u_b_h_w hold their last latched values.
- Latency: req high in cycle N (IDLE) → RAM access in cycle N+1 → ack in cycle N+2. Back-to-back throughput is one access per 3 cycles.
- A req arriving during ACCESS or RESP waits. It is sampled at the next IDLE.
- rdata is 0 for stores. For faulted loads, rdata equals ram_dout (0 for out-of-range addresses).
- Reset (also mid-access):
  - State = IDLE; all ack/fault/rdata = 0; ram_we = ram_re = 0; ram_addr = ram_din = 0; ram_u_b_h_w = 0.
  - last_grant = 1, so m0 wins the first tie.
  - A store interrupted in ACCESS by rst completes no write: ram_we is 0 from the reset edge on, before the negedge.

Optional Feature:
- Macro: DMEM_MISALIGN_CHECK_EN.
- Defined:
  - A half access with addr[0] = 1, or a word access with addr[1:0] != 0, is flagged at grant.
  - In ACCESS, ram_we = ram_re = 0.
  - RESP asserts fault = 1 with rdata = 0.
  - Latency stays 3 cycles.
- Undefined: no alignment check; the access passes to the RAM unchanged.

Test Plan:
- After reset, m0 store word 0xDEADBEEF to 0x10, then m0 load signed byte at 0x13 → ack 2 cycles after each req; rdata = 0xFFFFFFDE, fault = 0.
- m1 store half 0x80F0 to 0x20; m1 load unsigned half at 0x20 → rdata = 0x000080F0; signed half → rdata = 0xFFFF80F0.
- m0 and m1 request together in every IDLE, FIXED_PRIO = 0 → grants alternate m0, m1, m0, m1; each ack only to the owner; no ack overlap.
- m0 load at 0x00000100 → m0_fault = 1 with ack, rdata = 0. m1 store at 0x200 → m1_fault = 1, and RAM contents are unchanged.
- rst asserted during ACCESS of a store of 0x12345678 to 0x40 → outputs cleared next edge; read of 0x40 after reset returns the old value.
- With DMEM_MISALIGN_CHECK_EN: word load at 0x41 → fault = 1, ram_re stays 0, ack at cycle N+2.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester req/ack arbiter sequencing IDLE->ACCESS->RESP accesses to the data RAM.
// Define DMEM_MISALIGN_CHECK_EN to fault misaligned half/word accesses without touching the RAM.
module dmem_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [2:0]  m0_size,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  output logic        m0_fault,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [2:0]  m1_size,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        m1_fault,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  output logic        ram_we,
  output logic        ram_re,
  output logic [2:0]  ram_u_b_h_w,
  input  logic [31:0] ram_dout,
  input  logic        ram_l_fault,
  input  logic        ram_s_fault
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic        grant, owner, last_grant, start;
  logic        g_we, bad, we_q, bad_q, fault_q;
  logic [31:0] g_addr, g_wdata, addr_q, wdata_q, data_q;
  logic [2:0]  g_size, size_q;
  assign start = (state == IDLE) & (m0_req | m1_req);
  // On a tie the fixed mode favours m0; round-robin favours whoever lost last time.
  assign grant   = (m0_req & m1_req) ? ((FIXED_PRIO != 0) ? 1'b0 : ~last_grant) : m1_req;
  assign g_we    = grant ? m1_we    : m0_we;
  assign g_addr  = grant ? m1_addr  : m0_addr;
  assign g_wdata = grant ? m1_wdata : m0_wdata;
  assign g_size  = grant ? m1_size  : m0_size;
`ifdef DMEM_MISALIGN_CHECK_EN
  assign bad = g_size[1] ? (g_addr[1:0] != 2'b00) : (g_size[0] & g_addr[0]);
`else
  assign bad = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (state == IDLE) ? (start ? ACCESS : IDLE) :
               (state == ACCESS) ? RESP : IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      we_q       <= 1'b0;
      bad_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      data_q     <= '0;
      fault_q    <= 1'b0;
    end else begin
      if (start) begin
        owner      <= grant;
        last_grant <= grant;
        we_q       <= g_we;
        bad_q      <= bad;
        addr_q     <= g_addr;
        wdata_q    <= g_wdata;
        size_q     <= g_size;
      end
      if (state == ACCESS) begin
        data_q  <= (we_q | bad_q) ? '0 : ram_dout;
        fault_q <= bad_q | ram_l_fault | ram_s_fault;
      end
    end
  end
  // rst gates the strobes directly so a store cut off in ACCESS never reaches the negedge write.
  always_comb begin
    ram_we      = (state == ACCESS) & we_q & ~bad_q & ~rst;
    ram_re      = (state == ACCESS) & ~we_q & ~bad_q & ~rst;
    ram_addr    = addr_q;
    ram_din     = wdata_q;
    ram_u_b_h_w = size_q;
    m0_ack      = (state == RESP) & ~owner;
    m1_ack      = (state == RESP) & owner;
    m0_rdata    = m0_ack ? data_q : '0;
    m1_rdata    = m1_ack ? data_q : '0;
    m0_fault    = m0_ack & fault_q;
    m1_fault    = m1_ack & fault_q;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a behavioural 128 B data RAM.
module tb_dmem_arbiter;
  typedef struct packed {logic [31:0] rdata; logic fault;} exp_t;
  logic        clk, rst;
  logic        m0_req, m0_we, m0_ack, m0_fault, m1_req, m1_we, m1_ack, m1_fault;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [2:0]  m0_size, m1_size, ram_u_b_h_w;
  logic [31:0] ram_addr, ram_din, ram_dout, raw;
  logic        ram_we, ram_re, ram_l_fault, ram_s_fault, in_range, watch_re;
  logic [32:0] end_p;
  logic [6:0]  a0;
  logic [7:0]  mem [128];
  exp_t        q0[$], q1[$], e;
  int          order[$];
  int          n_vec = 0, n_err = 0;

  dmem_arbiter #(.FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_size(m0_size),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_fault(m0_fault),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_size(m1_size),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_fault(m1_fault),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_re(ram_re),
    .ram_u_b_h_w(ram_u_b_h_w), .ram_dout(ram_dout),
    .ram_l_fault(ram_l_fault), .ram_s_fault(ram_s_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: little-endian, combinational read, negedge write, out-of-range faults.
  always_comb begin
    end_p = {1'b0, ram_addr} + (ram_u_b_h_w[1] ? 33'd4 : ram_u_b_h_w[0] ? 33'd2 : 33'd1);
    in_range = end_p <= 33'd128;
    a0 = ram_addr[6:0];
    raw = {mem[a0 + 7'd3], mem[a0 + 7'd2], mem[a0 + 7'd1], mem[a0]};
    ram_dout = !in_range ? 32'h0 :
               ram_u_b_h_w[1] ? raw :
               ram_u_b_h_w[0] ? (ram_u_b_h_w[2] ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]}) :
               (ram_u_b_h_w[2] ? {24'h0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]});
    ram_l_fault = ram_re & !in_range;
    ram_s_fault = ram_we & !in_range;
  end

  always @(negedge clk)
    if (ram_we && in_range) begin
      mem[a0] = ram_din[7:0];
      if (ram_u_b_h_w[1] | ram_u_b_h_w[0]) mem[a0 + 7'd1] = ram_din[15:8];
      if (ram_u_b_h_w[1]) begin
        mem[a0 + 7'd2] = ram_din[23:16];
        mem[a0 + 7'd3] = ram_din[31:24];
      end
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every ack pops the owner's queue; non-owner outputs must be idle.
  always @(negedge clk)
    if (!rst) begin
      if (m0_ack | m1_ack) chk("ack_overlap", 32'(m0_ack & m1_ack), 0);
      if (m0_ack) begin
        if (q0.size() == 0) chk("m0_unexpected_ack", 1, 0);
        else begin
          e = q0.pop_front();
          chk("m0_rdata", m0_rdata, e.rdata);
          chk("m0_fault", 32'(m0_fault), 32'(e.fault));
          chk("m1_idle_rdata", m1_rdata, 0);
        end
        order.push_back(0);
      end
      if (m1_ack) begin
        if (q1.size() == 0) chk("m1_unexpected_ack", 1, 0);
        else begin
          e = q1.pop_front();
          chk("m1_rdata", m1_rdata, e.rdata);
          chk("m1_fault", 32'(m1_fault), 32'(e.fault));
          chk("m0_idle_rdata", m0_rdata, 0);
        end
        order.push_back(1);
      end
      if (watch_re && (ram_re || ram_we)) chk("misalign_ram_strobe", 1, 0);
    end

  task automatic access(input bit m, input bit we, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] er, input bit ef);
    int n = 0;
    if (m) begin
      q1.push_back('{er, ef});
      m1_we = we; m1_size = sz; m1_addr = a; m1_wdata = wd; m1_req = 1'b1;
    end else begin
      q0.push_back('{er, ef});
      m0_we = we; m0_size = sz; m0_addr = a; m0_wdata = wd; m0_req = 1'b1;
    end
    do begin
      @(posedge clk); #1; n++;
    end while (!(m ? m1_ack : m0_ack) && n < 10);
    chk("ack_latency", n, 2);
    if (m) m1_req = 1'b0; else m0_req = 1'b0;
    @(posedge clk); #1;
    chk("ack_pulse", 32'(m ? m1_ack : m0_ack), 0);
  endtask

  // Both requesters hold req through k accesses each; grants must alternate starting with m0.
  task automatic race(input int k);
    int c0 = 0, c1 = 0, n = 0;
    order.delete();
    for (int i = 0; i < k; i++) begin
      q0.push_back('{32'hDEADBEEF, 1'b0});
      q1.push_back('{32'h000080F0, 1'b0});
    end
    m0_we = 0; m0_addr = 32'h10; m0_size = 3'b010;
    m1_we = 0; m1_addr = 32'h20; m1_size = 3'b101;
    m0_req = 1'b1; m1_req = 1'b1;
    while ((c0 < k || c1 < k) && n < 20 * k) begin
      @(posedge clk); #1; n++;
      if (m0_ack) begin c0++; if (c0 == k) m0_req = 1'b0; end
      if (m1_ack) begin c1++; if (c1 == k) m1_req = 1'b0; end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk); #1;
    chk("race_acks", c0 + c1, 2 * k);
    chk("race_order_len", order.size(), 2 * k);
    for (int i = 0; i < order.size(); i++) chk("race_order", order[i], i % 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    watch_re = 0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_size = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_size = 0;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m0_ack", 32'(m0_ack), 0);
    chk("rst_m1_ack", 32'(m1_ack), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_re", 32'(ram_re), 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    rst = 0;
    @(posedge clk); #1;
    access(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    access(0, 0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 0);
    access(1, 1, 3'b001, 32'h20, 32'h000080F0, 32'h0, 0);
    access(1, 0, 3'b101, 32'h20, 32'h0, 32'h000080F0, 0);
    access(1, 0, 3'b001, 32'h20, 32'h0, 32'hFFFF80F0, 0);
    race(2);
    access(0, 0, 3'b010, 32'h100, 32'h0, 32'h0, 1);
    access(1, 1, 3'b010, 32'h200, 32'hCAFEF00D, 32'h0, 1);
    access(0, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    access(0, 1, 3'b010, 32'h40, 32'h0BADF00D, 32'h0, 0);
    m0_we = 1; m0_size = 3'b010; m0_addr = 32'h40; m0_wdata = 32'h12345678; m0_req = 1;
    @(posedge clk); #1;
    chk("abort_in_access", 32'(ram_we), 1);
    rst = 1; m0_req = 0;
    @(posedge clk); #1;
    chk("abort_ram_we", 32'(ram_we), 0);
    chk("abort_ram_addr", ram_addr, 0);
    chk("abort_ram_din", ram_din, 0);
    chk("abort_size", 32'(ram_u_b_h_w), 0);
    chk("abort_m0_ack", 32'(m0_ack), 0);
    rst = 0;
    @(posedge clk); #1;
    access(0, 0, 3'b010, 32'h40, 32'h0, 32'h0BADF00D, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    race(1);
`ifdef DMEM_MISALIGN_CHECK_EN
    watch_re = 1;
    access(0, 0, 3'b010, 32'h41, 32'h0, 32'h0, 1);
    access(1, 1, 3'b001, 32'h21, 32'hFFFF, 32'h0, 1);
    watch_re = 0;
    access(1, 0, 3'b101, 32'h20, 32'h0, 32'h000080F0, 0);
`endif
    chk("q0_drain", q0.size(), 0);
    chk("q1_drain", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
